// File: rtl/random_pick.sv
// random_pick: uniform index in [0, limit) from a free-running PRNG word via mask-and-reject.
// Optional RANDOM_PICK_NOISE_EN adds noise_p / resp_walk (random-walk decision).
module random_pick #(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = 8,
    parameter int MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rnd_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_limit,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDX_W-1:0] resp_index,
    output logic [7:0]       resp_tries,
    output logic             resp_fallback,
`ifdef RANDOM_PICK_NOISE_EN
    input  logic [7:0]       noise_p,
    output logic             resp_walk,
`endif
    output logic             resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] TRY_LAST = 8'(MAX_TRIES - 1);
    localparam logic [7:0] TRY_MAX  = 8'(MAX_TRIES);

    // Smallest 2^k-1 covering v: OR v with all of its right shifts.
    function automatic logic [IDX_W-1:0] smear(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = v;
        for (int i = 1; i < IDX_W; i++) begin
            m = m | (v >> i);
        end
        return m;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] limit_q, limit_d;
    logic [IDX_W-1:0] mask_q, mask_d;
    logic [7:0]       tries_q, tries_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             fb_q, fb_d;
    logic             err_q, err_d;
    logic             walk_q, walk_d;

    logic [IDX_W-1:0] cand;
    logic             walk_now;

    assign cand = rnd_in[IDX_W-1:0] & mask_q;

`ifdef RANDOM_PICK_NOISE_EN
    assign walk_now  = (rnd_in[WIDTH-1 -: 8] < noise_p);
    assign resp_walk = walk_q;
`else
    assign walk_now  = 1'b0;
`endif

    generate
        if (WIDTH > IDX_W) begin : g_unused
            logic unused_rnd;
            assign unused_rnd = ^rnd_in[WIDTH-1:IDX_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            limit_q <= '0;
            mask_q  <= '0;
            tries_q <= '0;
            index_q <= '0;
            fb_q    <= 1'b0;
            err_q   <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            mask_q  <= mask_d;
            tries_q <= tries_d;
            index_q <= index_d;
            fb_q    <= fb_d;
            err_q   <= err_d;
            walk_q  <= walk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        mask_d  = mask_q;
        tries_d = tries_q;
        index_d = index_q;
        fb_d    = fb_q;
        err_d   = err_q;
        walk_d  = walk_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    limit_d = req_limit;
                    mask_d  = smear(req_limit - IDX_W'(1));
                    tries_d = '0;
                    index_d = '0;
                    fb_d    = 1'b0;
                    walk_d  = 1'b0;
                    if (req_limit == '0) begin
                        mask_d  = '0;
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        err_d   = 1'b0;
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                if (cand < limit_q) begin
                    index_d = cand;
                    walk_d  = walk_now;
                    state_d = HOLD;
                end else if (tries_q == TRY_LAST) begin
                    // mask>>1 < limit, so the masked value is always in range
                    index_d = cand & (mask_q >> 1);
                    fb_d    = 1'b1;
                    tries_d = TRY_MAX;
                    walk_d  = walk_now;
                    state_d = HOLD;
                end else begin
                    tries_d = tries_q + 8'd1;
                end
            end
            HOLD: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == HOLD);
    assign resp_index    = index_q;
    assign resp_tries    = tries_q;
    assign resp_fallback = fb_q;
    assign resp_err      = err_q;

endmodule
